// File: rtl/mips_pkg.sv
// Shared constants and fetch-stage state encoding for the 32-bit MIPS core.
package mips_pkg;

  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {instr, pcplus4} holding buffer for a fetch that IF/ID cannot take yet.
module if_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] d_instr,
  input  logic [XLEN-1:0] d_pcplus4,
  output logic            full,
  output logic [XLEN-1:0] q_instr,
  output logic [XLEN-1:0] q_pcplus4
);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      full      <= 1'b0;
      q_instr   <= '0;
      q_pcplus4 <= '0;
    end else if (clear) begin
      full      <= 1'b0;
      q_instr   <= '0;
      q_pcplus4 <= '0;
    end else if (load) begin
      full      <= 1'b1;
      q_instr   <= d_instr;
      q_pcplus4 <= d_pcplus4;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: imem handshake, PC write enable and IF/ID register.
//   state   | meaning
//   S_REQ   | request at PCResult outstanding; ack delivers to IF/ID or skid
//   S_HOLD  | skid holds a fetched word while decode stalls; no request
//   S_DRAIN | cancelled request still outstanding at drain_addr; ack data dropped
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] PC_INCR   = mips_pkg::PC_INCR,
  parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [XLEN-1:0] PCResult,
  output logic            PC_w_en,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic            id_stall,
  output logic [XLEN-1:0] IFID_Instr,
  output logic [XLEN-1:0] IFID_PCPlus4,
  output logic            IFID_Valid
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] drain_addr;
  logic [XLEN-1:0] pc_plus;
  logic            accept;
  logic            req_raw, pc_w_raw;
  logic            ifid_load, ifid_from_skid;
  logic            skid_load, skid_clear, skid_full;
  logic            drain_load;
  logic [XLEN-1:0] skid_instr, skid_pcplus4;

  assign pc_plus = PCResult + PC_INCR;
  assign accept  = !IFID_Valid || !id_stall;

  if_skid_buf #(.XLEN(XLEN)) u_skid (
    .CLK       (CLK),
    .Reset     (Reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .d_instr   (imem_rdata),
    .d_pcplus4 (pc_plus),
    .full      (skid_full),
    .q_instr   (skid_instr),
    .q_pcplus4 (skid_pcplus4)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= S_REQ;
      drain_addr <= '0;
    end else begin
      state <= state_nxt;
      if (drain_load) drain_addr <= PCResult;
    end
  end

  always_comb begin
    state_nxt      = state;
    req_raw        = 1'b0;
    imem_addr      = PCResult;
    pc_w_raw       = 1'b0;
    ifid_load      = 1'b0;
    ifid_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    drain_load     = 1'b0;
    case (state)
      S_REQ: begin
        req_raw = 1'b1;
        if (imem_ack) begin
          pc_w_raw = 1'b1;
          if (!redirect) begin
            if (accept) begin
              ifid_load = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_nxt = S_HOLD;
            end
          end
        end else if (redirect) begin
          // The request cannot be withdrawn; remember its address until the ack.
          pc_w_raw   = 1'b1;
          drain_load = 1'b1;
          state_nxt  = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          skid_clear = 1'b1;
          pc_w_raw   = 1'b1;
          state_nxt  = S_REQ;
        end else if (!id_stall) begin
          ifid_load      = 1'b1;
          ifid_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_nxt      = S_REQ;
        end
      end
      S_DRAIN: begin
        req_raw   = 1'b1;
        imem_addr = drain_addr;
        pc_w_raw  = redirect;
        if (imem_ack) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
  end

  assign imem_req = req_raw  && Reset;
  assign PC_w_en  = pc_w_raw && Reset;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      IFID_Instr   <= NOP_INSTR;
      IFID_PCPlus4 <= '0;
      IFID_Valid   <= 1'b0;
    end else if (redirect) begin
      IFID_Instr <= NOP_INSTR;
      IFID_Valid <= 1'b0;
    end else if (ifid_load) begin
      IFID_Instr   <= ifid_from_skid ? skid_instr   : imem_rdata;
      IFID_PCPlus4 <= ifid_from_skid ? skid_pcplus4 : pc_plus;
      IFID_Valid   <= 1'b1;
    end else if (IFID_Valid && !id_stall) begin
      IFID_Instr <= NOP_INSTR;
      IFID_Valid <= 1'b0;
    end
  end

  // skid_full is implied by state == S_HOLD; kept for visibility in waveforms.
  logic unused_skid_full;
  assign unused_skid_full = skid_full;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed fetches, stalls, redirects, reset.
module tb_if_fetch_stage;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] PCResult;
  logic        PC_w_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic        id_stall;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  if_fetch_stage dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .PCResult     (PCResult),
    .PC_w_en      (PC_w_en),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .id_stall     (id_stall),
    .IFID_Instr   (IFID_Instr),
    .IFID_PCPlus4 (IFID_PCPlus4),
    .IFID_Valid   (IFID_Valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_comb(input string nm, input logic req, input logic [31:0] addr,
                          input logic pcw);
    chk({nm, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({nm, "_addr"}, imem_addr, addr);
    chk({nm, "_pcw"}, {31'd0, PC_w_en}, {31'd0, pcw});
  endtask

  task automatic drive(input logic [31:0] pc, input logic ack, input logic [31:0] rd,
                       input logic redir, input logic stall);
    PCResult   = pc;
    imem_ack   = ack;
    imem_rdata = rd;
    redirect   = redir;
    id_stall   = stall;
    @(negedge CLK);
  endtask

  task automatic adv;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    exp_q.push_back(e);
  endtask

  // An instruction is delivered when IF/ID is valid and decode takes it at the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (Reset && IFID_Valid && !id_stall && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery actual=%h required=none", IFID_Instr);
        end else begin
          e = exp_q.pop_front();
          chk("deliv_instr", IFID_Instr, e.instr);
          chk("deliv_pc4", IFID_PCPlus4, e.pc4);
        end
      end
    end
  end

  initial begin
    Reset = 1'b0;
    PCResult = '0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; id_stall = 1'b0;
    #1;
    chk_comb("rst", 1'b0, 32'h0, 1'b0);
    chk("rst_valid", {31'd0, IFID_Valid}, 32'd0);
    chk("rst_instr", IFID_Instr, 32'h0);
    chk("rst_pc4", IFID_PCPlus4, 32'h0);
    adv;
    adv;
    Reset = 1'b1;

    // zero-wait fetch
    drive(32'h0, 1'b1, 32'h2008_0005, 1'b0, 1'b0);
    chk_comb("zw", 1'b1, 32'h0, 1'b1);
    push(32'h2008_0005, 32'h4);
    adv;
    chk("zw_valid", {31'd0, IFID_Valid}, 32'd1);
    chk("zw_instr", IFID_Instr, 32'h2008_0005);
    chk("zw_pc4", IFID_PCPlus4, 32'h4);

    // three wait states
    for (int i = 0; i < 3; i++) begin
      drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_comb("wait", 1'b1, 32'h100, 1'b0);
      adv;
    end
    drive(32'h100, 1'b1, 32'h1111_0000, 1'b0, 1'b0);
    chk_comb("wait_ack", 1'b1, 32'h100, 1'b1);
    push(32'h1111_0000, 32'h104);
    adv;
    chk("wait_pc4", IFID_PCPlus4, 32'h104);

    // decode stall pushes the next fetch into the skid
    drive(32'h104, 1'b1, 32'hAAAA_0001, 1'b0, 1'b1);
    chk_comb("skid_ld", 1'b1, 32'h104, 1'b1);
    push(32'hAAAA_0001, 32'h108);
    adv;
    chk("skid_hold_instr", IFID_Instr, 32'h1111_0000);
    drive(32'h108, 1'b0, 32'h0, 1'b0, 1'b1);
    chk_comb("hold", 1'b0, 32'h0, 1'b0);
    adv;
    chk("hold_instr", IFID_Instr, 32'h1111_0000);
    drive(32'h108, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_comb("hold_rel", 1'b0, 32'h0, 1'b0);
    adv;
    chk("skid_out_instr", IFID_Instr, 32'hAAAA_0001);
    chk("skid_out_valid", {31'd0, IFID_Valid}, 32'd1);

    // redirect with request pending -> drain, including a second redirect while draining
    drive(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_comb("pend", 1'b1, 32'h200, 1'b0);
    adv;
    drive(32'h200, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_comb("redir", 1'b1, 32'h200, 1'b1);
    adv;
    chk("redir_valid", {31'd0, IFID_Valid}, 32'd0);
    drive(32'h400, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_comb("drain", 1'b1, 32'h200, 1'b0);
    adv;
    drive(32'h400, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_comb("drain_redir", 1'b1, 32'h200, 1'b1);
    adv;
    drive(32'h480, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk_comb("drain_ack", 1'b1, 32'h200, 1'b0);
    adv;
    chk("drain_valid", {31'd0, IFID_Valid}, 32'd0);
    drive(32'h480, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_comb("post_drain", 1'b1, 32'h480, 1'b0);
    adv;

    // redirect beats id_stall with IF/ID valid and skid full
    drive(32'h480, 1'b1, 32'h3000_0001, 1'b0, 1'b0);
    chk_comb("pre_a", 1'b1, 32'h480, 1'b1);
    adv;
    drive(32'h484, 1'b1, 32'h3000_0002, 1'b0, 1'b1);
    chk_comb("pre_b", 1'b1, 32'h484, 1'b1);
    adv;
    chk("pre_b_instr", IFID_Instr, 32'h3000_0001);
    drive(32'h488, 1'b0, 32'h0, 1'b1, 1'b1);
    chk_comb("kill", 1'b0, 32'h0, 1'b1);
    adv;
    chk("kill_valid", {31'd0, IFID_Valid}, 32'd0);
    chk("kill_instr", IFID_Instr, 32'h0);
    drive(32'h800, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_comb("kill_after", 1'b1, 32'h800, 1'b0);
    adv;

    // PC+4 wraps
    drive(32'hFFFF_FFFC, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
    chk_comb("wrap", 1'b1, 32'hFFFF_FFFC, 1'b1);
    push(32'h0BAD_F00D, 32'h0);
    adv;
    chk("wrap_pc4", IFID_PCPlus4, 32'h0);

    // reset asserted mid-drain
    drive(32'h10, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    push(32'h1234_5678, 32'h14);
    adv;
    drive(32'h14, 1'b0, 32'h0, 1'b0, 1'b0);
    adv;
    drive(32'h14, 1'b0, 32'h0, 1'b1, 1'b0);
    adv;
    drive(32'h900, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_comb("md_drain", 1'b1, 32'h14, 1'b0);
    #2;
    Reset = 1'b0;
    #1;
    chk_comb("md_rst", 1'b0, 32'h0, 1'b0);
    chk("md_rst_pc4", IFID_PCPlus4, 32'h0);
    chk("md_rst_valid", {31'd0, IFID_Valid}, 32'd0);
    chk("md_rst_instr", IFID_Instr, 32'h0);
    adv;
    Reset = 1'b1;
    drive(32'h900, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_comb("post_rst", 1'b1, 32'h900, 1'b0);
    adv;
    drive(32'h900, 1'b1, 32'h5555_5555, 1'b0, 1'b0);
    chk_comb("final", 1'b1, 32'h900, 1'b1);
    push(32'h5555_5555, 32'h904);
    adv;
    drive(32'h904, 1'b0, 32'h0, 1'b0, 1'b0);
    adv;

    chk("queue_left", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
